axis2lbus: RTL

//  TX-side converter: 512-bit AXI4-Stream packets in, 4-segment (4x128b) CMAC LBUS TX out.

---
 rtl/axis2lbus.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/axis2lbus.sv
// AXI4-Stream (512b) to CMAC 4-segment LBUS TX converter.
// Beats are mapped to LBUS words at write time and buffered in a word FIFO with a start-hold policy.
module axis2lbus #(
  parameter int DEPTH        = 16,
  parameter int START_THRESH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] s_axis_tdata,
  input  logic [63:0]  s_axis_tkeep,
  input  logic         s_axis_tlast,
  input  logic         s_axis_tuser,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [127:0] tx_lbus_seg0_data,
  output logic         tx_lbus_seg0_ena,
  output logic         tx_lbus_seg0_sop,
  output logic         tx_lbus_seg0_eop,
  output logic [3:0]   tx_lbus_seg0_mty,
  output logic         tx_lbus_seg0_err,
  output logic [127:0] tx_lbus_seg1_data,
  output logic         tx_lbus_seg1_ena,
  output logic         tx_lbus_seg1_sop,
  output logic         tx_lbus_seg1_eop,
  output logic [3:0]   tx_lbus_seg1_mty,
  output logic         tx_lbus_seg1_err,
  output logic [127:0] tx_lbus_seg2_data,
  output logic         tx_lbus_seg2_ena,
  output logic         tx_lbus_seg2_sop,
  output logic         tx_lbus_seg2_eop,
  output logic [3:0]   tx_lbus_seg2_mty,
  output logic         tx_lbus_seg2_err,
  output logic [127:0] tx_lbus_seg3_data,
  output logic         tx_lbus_seg3_ena,
  output logic         tx_lbus_seg3_sop,
  output logic         tx_lbus_seg3_eop,
  output logic [3:0]   tx_lbus_seg3_mty,
  output logic         tx_lbus_seg3_err,
  input  logic         tx_rdyout,
  input  logic         tx_ovfout,
  input  logic         tx_unfout,
  output logic         ovf_sticky,
  output logic         unf_sticky,
  output logic         dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0][127:0] data;
    logic [3:0]        ena;
    logic              sop;
    logic [3:0]        eop;
    logic [3:0][3:0]   mty;
    logic [3:0]        err;
  } word_t;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  // Handshake: a beat transfers on a rising edge where s_axis_tvalid and s_axis_tready are both 1;
  // the LBUS side has no handshake, a word is consumed in every cycle its ena bits are set.
  word_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d, eop_cnt_q, eop_cnt_d;
  logic           in_pkt_q, rdy_q, ovf_q, unf_q;
  state_e         state_q;
  word_t          out_q, wr_word, head;
  logic [15:0]    keep_seg [4];
  logic [3:0]     seg_en;
  logic [1:0]     last_seg;
  logic           push, pop, head_eop, start_ok;

  assign s_axis_tready = rst_n & (count_q < CW'(DEPTH - 2));
  // An all-zero keep without tlast carries no bytes and is swallowed.
  assign push = s_axis_tvalid & s_axis_tready & (s_axis_tlast | (|s_axis_tkeep));

  always_comb begin
    wr_word  = '0;
    last_seg = '0;
    keep_seg = '{default: '0};
    seg_en   = '0;
    for (int i = 0; i < 4; i++) begin
      keep_seg[i] = s_axis_tkeep[63-16*i -: 16];
      seg_en[i]   = |keep_seg[i];
      if (seg_en[i]) last_seg = 2'(i);
    end
    wr_word.sop = ~in_pkt_q;
    if (!s_axis_tlast) begin
      wr_word.ena = 4'hf;
      for (int i = 0; i < 4; i++) wr_word.data[i] = s_axis_tdata[511-128*i -: 128];
    end else if (s_axis_tkeep == '0) begin
      wr_word.ena[0]  = 1'b1;
      wr_word.eop[0]  = 1'b1;
      wr_word.err[0]  = 1'b1;
      wr_word.data[0] = s_axis_tdata[511:384];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (seg_en[i]) begin
          wr_word.ena[i]  = 1'b1;
          wr_word.data[i] = s_axis_tdata[511-128*i -: 128];
        end
      end
      wr_word.eop[last_seg] = 1'b1;
      wr_word.err[last_seg] = s_axis_tuser;
      wr_word.mty[last_seg] = 4'(5'd16 - 5'($countones(keep_seg[last_seg])));
    end
  end

  assign head     = mem[rd_ptr_q];
  assign head_eop = |head.eop;
  // Hold a packet start until it is either complete in the FIFO or deep enough not to underflow.
  assign start_ok = (count_q != '0) && head.sop &&
                    ((eop_cnt_q != '0) || (count_q >= CW'(START_THRESH)));
  assign pop      = rdy_q && (count_q != '0) && ((state_q == SEND) || start_ok);

  assign count_d   = count_q + CW'(push) - CW'(pop);
  assign eop_cnt_d = eop_cnt_q + CW'(push & (|wr_word.eop)) - CW'(pop & head_eop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      eop_cnt_q <= '0;
      in_pkt_q  <= 1'b0;
      rdy_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      state_q   <= IDLE;
      out_q     <= '0;
    end else begin
      rdy_q     <= tx_rdyout;
      ovf_q     <= ovf_q | tx_ovfout;
      unf_q     <= unf_q | tx_unfout;
      count_q   <= count_d;
      eop_cnt_q <= eop_cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        in_pkt_q <= ~s_axis_tlast;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        out_q    <= head;
        state_q  <= head_eop ? IDLE : SEND;
      end else begin
        out_q <= '0;
      end
    end
  end

  assign ovf_sticky  = ovf_q;
  assign unf_sticky  = unf_q;
  assign dbg_state_o = state_q;

  assign tx_lbus_seg0_data = out_q.data[0];
  assign tx_lbus_seg0_ena  = out_q.ena[0];
  assign tx_lbus_seg0_sop  = out_q.sop;
  assign tx_lbus_seg0_eop  = out_q.eop[0];
  assign tx_lbus_seg0_mty  = out_q.mty[0];
  assign tx_lbus_seg0_err  = out_q.err[0];
  assign tx_lbus_seg1_data = out_q.data[1];
  assign tx_lbus_seg1_ena  = out_q.ena[1];
  assign tx_lbus_seg1_sop  = 1'b0;
  assign tx_lbus_seg1_eop  = out_q.eop[1];
  assign tx_lbus_seg1_mty  = out_q.mty[1];
  assign tx_lbus_seg1_err  = out_q.err[1];
  assign tx_lbus_seg2_data = out_q.data[2];
  assign tx_lbus_seg2_ena  = out_q.ena[2];
  assign tx_lbus_seg2_sop  = 1'b0;
  assign tx_lbus_seg2_eop  = out_q.eop[2];
  assign tx_lbus_seg2_mty  = out_q.mty[2];
  assign tx_lbus_seg2_err  = out_q.err[2];
  assign tx_lbus_seg3_data = out_q.data[3];
  assign tx_lbus_seg3_ena  = out_q.ena[3];
  assign tx_lbus_seg3_sop  = 1'b0;
  assign tx_lbus_seg3_eop  = out_q.eop[3];
  assign tx_lbus_seg3_mty  = out_q.mty[3];
  assign tx_lbus_seg3_err  = out_q.err[3];

endmodule
